md_unit: RTL and testbench

Multi-cycle multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline. It sits in the EX stage beside the ALU and accepts mult/multu/div/divu operations. It holds the result in HI/LO for mfhi/mflo, and drives a `busy` flag that the pipeline stall controller uses to hold any D-stage HI/LO consumer until the operation retires.

---
 rtl/md_unit_if.sv | 33 +++
 rtl/md_unit.sv | 160 ++++++++++++++++
 tb/tb_md_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Bundle between the EX stage and the multiply/divide unit.
//               The pipeline side drives the md instruction and mthi/mtlo
//               requests; the unit returns busy and the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  // Pipeline / EX-stage side
  modport master (
    output start, op, A, B, hi_we, lo_we, wdata,
    input  busy, HI, LO
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, A, B, hi_we, lo_we, wdata,
    output busy, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle multiply/divide unit with HI/LO registers for the
//               5-stage MIPS pipeline. The result is computed when the
//               operation is accepted, held in an internal latch, and written
//               to HI/LO once the fixed latency has elapsed.
//               Optional macro MD_DIV0_HOLD_EN: when defined, a divide by
//               zero is accepted without going busy and leaves HI/LO as they
//               are. When undefined, it follows the normal divide path and
//               writes HI=A, LO=0xFFFFFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,   // 1..15
  parameter int DIV_CYCLES  = 10   // 1..15
) (
  input  wire logic clk,
  input  wire logic reset_n,
  md_unit_if.slave  md
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [63:0] res_q,   res_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  // --------------------------------------------------------------------------
  // Arithmetic datapath (operands are the forwarded values present with start)
  // --------------------------------------------------------------------------
  logic [63:0] w_mul_s;
  logic [63:0] w_mul_u;
  logic        w_b_zero;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_sdiv_den;
  logic [31:0] w_udiv_den;
  logic [31:0] w_mag_quo;
  logic [31:0] w_mag_rem;
  logic [31:0] w_s_quo;
  logic [31:0] w_s_rem;
  logic [31:0] w_u_quo;
  logic [31:0] w_u_rem;
  logic [63:0] w_result;

  // Signed product: the low 64 bits of the sign-extended product are exact.
  assign w_mul_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
  assign w_mul_u = {32'd0, md.A} * {32'd0, md.B};

  assign w_b_zero = (md.B == 32'd0);

  // Signed divide done on magnitudes: quotient sign is the XOR of operand
  // signs, remainder sign follows the dividend. 0x80000000 / -1 falls out
  // naturally as quotient 0x80000000, remainder 0.
  assign w_a_neg = md.A[31];
  assign w_b_neg = md.B[31];
  assign w_a_mag = w_a_neg ? (32'd0 - md.A) : md.A;
  assign w_b_mag = w_b_neg ? (32'd0 - md.B) : md.B;

  // Keep the divider free of a zero divisor; the zero case is substituted below.
  assign w_sdiv_den = w_b_zero ? 32'd1 : w_b_mag;
  assign w_udiv_den = w_b_zero ? 32'd1 : md.B;

  assign w_mag_quo = w_a_mag / w_sdiv_den;
  assign w_mag_rem = w_a_mag % w_sdiv_den;
  assign w_s_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_mag_quo) : w_mag_quo;
  assign w_s_rem   = w_a_neg ? (32'd0 - w_mag_rem) : w_mag_rem;

  assign w_u_quo = md.A / w_udiv_den;
  assign w_u_rem = md.A % w_udiv_den;

  // Select the 64-bit {HI, LO} image for the requested operation.
  always_comb begin
    w_result = 64'd0;
    case (md.op)
      2'b00:   w_result = w_mul_s;
      2'b01:   w_result = w_mul_u;
      2'b10:   w_result = w_b_zero ? {md.A, 32'hFFFF_FFFF} : {w_s_rem, w_s_quo};
      default: w_result = w_b_zero ? {md.A, 32'hFFFF_FFFF} : {w_u_rem, w_u_quo};
    endcase
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------

  // State register, counter, result latch and HI/LO with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: accept in IDLE (start beats mthi/mtlo), count in BUSY,
  // retire into HI/LO when the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md.start) begin
`ifdef MD_DIV0_HOLD_EN
          if (!(md.op[1] && w_b_zero)) begin
            res_d   = w_result;
            cnt_d   = md.op[1] ? c_DIV_LOAD : c_MULT_LOAD;
            state_d = S_BUSY;
          end
`else
          res_d   = w_result;
          cnt_d   = md.op[1] ? c_DIV_LOAD : c_MULT_LOAD;
          state_d = S_BUSY;
`endif
        end else begin
          if (md.hi_we) hi_d = md.wdata;
          if (md.lo_we) lo_d = md.wdata;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md.busy = (state_q == S_BUSY);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit. A behavioural model computes
//               expected HI/LO from native 64-bit arithmetic; busy length is
//               measured against the configured cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference result {HI, LO} from plain signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Whether the operation is expected to go busy and write HI/LO, and for how long.
  function automatic int ref_busy(input logic [1:0] o, input logic [31:0] b);
`ifdef MD_DIV0_HOLD_EN
    if (o[1] && b == 32'd0) return 0;
`endif
    return o[1] ? DIV_N : MULT_N;
  endfunction

  // Present an op at the current negedge, then count busy cycles until idle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int nb);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    nb = 0;
    while (bus.busy && nb <= 40) begin
      nb++;
      @(negedge clk);
    end
  endtask

  // Model update after an op has retired.
  task automatic model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    if (ref_busy(o, b) != 0) begin
      r = ref_result(o, a, b);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
  endtask

  task automatic test_reset;
    bus.start = 0; bus.op = 0; bus.A = 0; bus.B = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", bus.busy, bus.HI, bus.LO);
    end
    reset_n = 1'b1;
    @(negedge clk);
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic run_checked(input string nm, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b);
    int nb;
    do_op(o, a, b, nb);
    model_op(o, a, b);
    checks++;
    if (nb !== ref_busy(o, b)) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d required %0d", nm, nb, ref_busy(o, b));
    end
    checks++;
    if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      failures++;
      $display("FAIL %s result op=%0d A=%h B=%h: HI=%h LO=%h required HI=%h LO=%h",
               nm, o, a, b, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mult;
    run_checked("mult_neg2x3", 2'b00, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL mult_neg2x3_const: HI=%h LO=%h required HI=ffffffff LO=fffffffa", bus.HI, bus.LO);
    end
    run_checked("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (bus.HI !== 32'hFFFF_FFFE || bus.LO !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_max_const: HI=%h LO=%h required HI=fffffffe LO=00000001", bus.HI, bus.LO);
    end
    run_checked("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div;
    run_checked("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_neg7_2_const: HI=%h LO=%h required HI=ffffffff LO=fffffffd", bus.HI, bus.LO);
    end
    run_checked("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_ovf_const: HI=%h LO=%h required HI=0 LO=80000000", bus.HI, bus.LO);
    end
    run_checked("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE);
    run_checked("divu_big", 2'b11, 32'hFFFF_FFF9, 32'd2);
  endtask

  task automatic test_write_priority;
    int nb;
    // Plain mthi in IDLE
    bus.hi_we = 1; bus.wdata = 32'hCAFE_0001;
    @(negedge clk);
    bus.hi_we = 0;
    exp_hi = 32'hCAFE_0001;
    checks++;
    if (bus.HI !== exp_hi) begin
      failures++;
      $display("FAIL mthi_idle: HI=%h required %h", bus.HI, exp_hi);
    end
    // start with concurrent hi_we: write dropped
    bus.start = 1; bus.op = 2'b00; bus.A = 32'd2; bus.B = 32'd3;
    bus.hi_we = 1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.start = 0; bus.hi_we = 0;
    checks++;
    if (bus.HI !== 32'hCAFE_0001 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_beats_mthi: HI=%h busy=%b required HI=cafe0001 busy=1", bus.HI, bus.busy);
    end
    nb = 1;
    while (bus.busy && nb <= 40) begin @(negedge clk); if (bus.busy) nb++; end
    model_op(2'b00, 32'd2, 32'd3);
    checks++;
    if (nb !== MULT_N || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      failures++;
      $display("FAIL start_beats_mthi_result: cycles=%0d HI=%h LO=%h required cycles=%0d HI=%h LO=%h",
               nb, bus.HI, bus.LO, MULT_N, exp_hi, exp_lo);
    end
    // mthi and a stray start during BUSY: both ignored
    bus.start = 1; bus.op = 2'b01; bus.A = 32'd7; bus.B = 32'd9;
    @(negedge clk);
    bus.start = 1; bus.op = 2'b10; bus.A = 32'd100; bus.B = 32'd7;
    bus.hi_we = 1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.start = 0; bus.hi_we = 0;
    checks++;
    if (bus.HI !== exp_hi) begin
      failures++;
      $display("FAIL mthi_busy_ignored: HI=%h required %h", bus.HI, exp_hi);
    end
    nb = 2;
    while (bus.busy && nb <= 40) begin @(negedge clk); if (bus.busy) nb++; end
    model_op(2'b01, 32'd7, 32'd9);
    checks++;
    if (nb !== MULT_N || bus.HI !== exp_hi || bus.LO !== exp_lo || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignores_start: cycles=%0d HI=%h LO=%h busy=%b required cycles=%0d HI=%h LO=%h busy=0",
               nb, bus.HI, bus.LO, bus.busy, MULT_N, exp_hi, exp_lo);
    end
    // mtlo in IDLE
    bus.lo_we = 1; bus.wdata = 32'h55;
    @(negedge clk);
    bus.lo_we = 0;
    exp_lo = 32'h55;
    checks++;
    if (bus.LO !== exp_lo || bus.HI !== exp_hi) begin
      failures++;
      $display("FAIL mtlo_idle: HI=%h LO=%h required HI=%h LO=%h", bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back;
    int nb;
    run_checked("b2b_first", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    // do_op issues right away, i.e. at the first edge after busy fell
    run_checked("b2b_second", 2'b11, 32'hDEAD_BEEF, 32'd17);
    run_checked("b2b_third", 2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    nb = 0;
  endtask

  task automatic test_reset_mid_op;
    bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    bus.hi_we = 0; bus.lo_we = 0;
    bus.start = 1; bus.op = 2'b11; bus.A = 32'd1000; bus.B = 32'd3;
    @(negedge clk);
    bus.start = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midop_busy_before_reset: busy=%b required 1", bus.busy);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_hi = 0; exp_lo = 0;
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL midop_reset: busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", bus.busy, bus.HI, bus.LO);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL midop_no_late_write: busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", bus.busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_div0;
    bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.hi_we = 0; bus.lo_we = 0;
    exp_hi = 32'h0BAD_F00D; exp_lo = 32'h0BAD_F00D;
    run_checked("div0_signed", 2'b10, 32'hFFFF_FF00, 32'd0);
    run_checked("div0_unsigned", 2'b11, 32'h1357_9BDF, 32'd0);
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 50)) - 32'd25;
        default: ;
      endcase
      run_checked("random", o, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_write_priority();
    test_back_to_back();
    test_reset_mid_op();
    test_div0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
